// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: glyph patterns (a = MSB),
// FSM state encoding and event payload layout.
package seg7_pkg;

  localparam int unsigned SEGW = 7;
  localparam int unsigned VALW = 4;

  localparam logic [SEGW-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEGW-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEGW-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEGW-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEGW-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEGW-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEGW-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEGW-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEGW-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEGW-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEGW-1:0] SEG_A     = 7'b1110111;
  localparam logic [SEGW-1:0] SEG_B     = 7'b0011111;
  localparam logic [SEGW-1:0] SEG_C     = 7'b1001110;
  localparam logic [SEGW-1:0] SEG_D     = 7'b0111101;
  localparam logic [SEGW-1:0] SEG_E     = 7'b1001111;
  localparam logic [SEGW-1:0] SEG_F     = 7'b1000111;
  localparam logic [SEGW-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  typedef struct packed {
    logic [VALW-1:0] val;
    logic            err;
    logic            blank;
  } ev_payload_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Inverse 7-segment decoder: pattern -> nibble, flags legal glyph or all-off.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  logic [SEGW-1:0] seg,
  output logic [VALW-1:0] val,
  output logic            legal,
  output logic            blank
);

  always_comb begin
    val   = '0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0:     val = 4'h0;
      SEG_1:     val = 4'h1;
      SEG_2:     val = 4'h2;
      SEG_3:     val = 4'h3;
      SEG_4:     val = 4'h4;
      SEG_5:     val = 4'h5;
      SEG_6:     val = 4'h6;
      SEG_7:     val = 4'h7;
      SEG_8:     val = 4'h8;
      SEG_9:     val = 4'h9;
      SEG_A:     val = 4'hA;
      SEG_B:     val = 4'hB;
      SEG_C:     val = 4'hC;
      SEG_D:     val = 4'hD;
      SEG_E:     val = 4'hE;
      SEG_F:     val = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment bus reader: debounces each digit window, keeps a value
// table and reports table changes through a single-entry valid/ready slot.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned IDXW       = 2,
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned CNTW       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEGW-1:0]      seg,
  input  logic [NDIG-1:0]      dig_en,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [IDXW-1:0]      ev_idx,
  output logic [VALW-1:0]      ev_val,
  output logic                 ev_err,
  output logic                 ev_blank,
  output logic [VALW*NDIG-1:0] digits,
  output logic [NDIG-1:0]      dig_vld,
  output logic                 ovf
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NDIG-1:0] prev_en_q;
  logic [SEGW-1:0] prev_seg_q;

  logic            onehot_c, changed_c, capture_c, xfer_c;
  logic [IDXW-1:0] idx_c;
  logic [VALW-1:0] hex_val_c, cur_val_c;
  logic            hex_legal_c, hex_blank_c;
  logic            ev_gen_c, tab_set_c, tab_clr_c;
  ev_payload_t     ev_new_c;

  seg7_to_hex u_dec (
    .seg   (seg),
    .val   (hex_val_c),
    .legal (hex_legal_c),
    .blank (hex_blank_c)
  );

  assign onehot_c  = $onehot(dig_en);
  assign changed_c = {dig_en, seg} != {prev_en_q, prev_seg_q};
  assign cur_val_c = digits[VALW*idx_c +: VALW];
  assign xfer_c    = ev_valid & ev_ready;

  // One-hot digit enable to index
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dig_en[i]) idx_c = IDXW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prev_en_q  <= '0;
      prev_seg_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_en_q  <= dig_en;
      prev_seg_q <= seg;
    end
  end

  // Stability window: any input change restarts the count at 1
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    if (!onehot_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (changed_c || state_q == IDLE) begin
      state_d = COUNT;
      cnt_d   = CNTW'(1);
    end else if (state_q == COUNT) begin
      if (cnt_q == CNTW'(STABLE_CYC - 1)) begin
        capture_c = 1'b1;
        state_d   = LOCKED;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Capture classification: only table changes and errors raise events
  always_comb begin
    ev_gen_c  = 1'b0;
    tab_set_c = 1'b0;
    tab_clr_c = 1'b0;
    ev_new_c  = '0;
    if (capture_c) begin
      if (hex_legal_c) begin
        if (!dig_vld[idx_c] || cur_val_c != hex_val_c) begin
          tab_set_c    = 1'b1;
          ev_gen_c     = 1'b1;
          ev_new_c.val = hex_val_c;
        end
      end else if (hex_blank_c) begin
        if (dig_vld[idx_c]) begin
          tab_clr_c      = 1'b1;
          ev_gen_c       = 1'b1;
          ev_new_c.blank = 1'b1;
        end
      end else begin
        ev_gen_c     = 1'b1;
        ev_new_c.err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits  <= '0;
      dig_vld <= '0;
    end else if (tab_set_c) begin
      digits[VALW*idx_c +: VALW] <= hex_val_c;
      dig_vld[idx_c]             <= 1'b1;
    end else if (tab_clr_c) begin
      dig_vld[idx_c] <= 1'b0;
    end
  end

  // Event slot: a capture may reload on the same edge the old event leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_idx   <= '0;
      ev_val   <= '0;
      ev_err   <= 1'b0;
      ev_blank <= 1'b0;
      ovf      <= 1'b0;
    end else if (ev_gen_c && (!ev_valid || xfer_c)) begin
      ev_valid <= 1'b1;
      ev_idx   <= idx_c;
      ev_val   <= ev_new_c.val;
      ev_err   <= ev_new_c.err;
      ev_blank <= ev_new_c.blank;
    end else begin
      if (ev_gen_c) ovf <= 1'b1;
      if (xfer_c) ev_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_seg7_scan_decoder;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_en = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid, ev_err, ev_blank, ovf;
  logic [1:0]  ev_idx;
  logic [3:0]  ev_val;
  logic [15:0] digits;
  logic [3:0]  dig_vld;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] val;
    logic       err;
    logic       blank;
  } evrec_t;

  evrec_t log_q[$];

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(4), .IDXW(2), .STABLE_CYC(4), .CNTW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .seg      (seg),
    .dig_en   (dig_en),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_idx   (ev_idx),
    .ev_val   (ev_val),
    .ev_err   (ev_err),
    .ev_blank (ev_blank),
    .digits   (digits),
    .dig_vld  (dig_vld),
    .ovf      (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: run length of identical one-hot inputs, table and single event slot
  logic        m_valid, m_err, m_blank, m_ovf;
  logic [1:0]  m_idx;
  logic [3:0]  m_val;
  logic [15:0] m_digits;
  logic [3:0]  m_dvld;
  logic [3:0]  m_last_en;
  logic [6:0]  m_last_seg;
  int          m_run;

  always @(posedge clk or posedge rst) begin : model
    bit         xfer, gen, nerr, nblank;
    int         idx, code;
    logic [3:0] nval;
    if (rst) begin
      m_valid = 0; m_err = 0; m_blank = 0; m_ovf = 0; m_idx = 0; m_val = 0;
      m_digits = 0; m_dvld = 0; m_last_en = 0; m_last_seg = 0; m_run = 0;
    end else begin
      xfer = m_valid && ev_ready;
      gen = 0; nerr = 0; nblank = 0; nval = 0; idx = 0;
      if ($onehot(dig_en))
        m_run = (dig_en == m_last_en && seg == m_last_seg) ? m_run + 1 : 1;
      else
        m_run = 0;
      m_last_en = dig_en;
      m_last_seg = seg;
      if (m_run == STABLE) begin
        for (int i = 0; i < 4; i++) if (dig_en[i]) idx = i;
        code = -1;
        for (int v = 0; v < 16; v++) if (seg == glyph[v]) code = v;
        if (code >= 0) begin
          if (!m_dvld[idx] || m_digits[idx*4 +: 4] != 4'(code)) begin
            m_digits[idx*4 +: 4] = 4'(code);
            m_dvld[idx] = 1'b1;
            gen = 1; nval = 4'(code);
          end
        end else if (seg == 7'b0) begin
          if (m_dvld[idx]) begin
            m_dvld[idx] = 1'b0;
            gen = 1; nblank = 1;
          end
        end else begin
          gen = 1; nerr = 1;
        end
      end
      if (gen && (!m_valid || xfer)) begin
        m_valid = 1; m_idx = 2'(idx); m_val = nval; m_err = nerr; m_blank = nblank;
      end else if (gen) begin
        m_ovf = 1;
      end else if (xfer) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle compare and log of accepted events
  always @(negedge clk) begin : compare
    evrec_t r;
    if (started) begin
      chk("ev_valid", 32'(ev_valid), 32'(m_valid));
      if (m_valid) begin
        chk("ev_idx", 32'(ev_idx), 32'(m_idx));
        chk("ev_val", 32'(ev_val), 32'(m_val));
        chk("ev_err", 32'(ev_err), 32'(m_err));
        chk("ev_blank", 32'(ev_blank), 32'(m_blank));
      end
      chk("digits", 32'(digits), 32'(m_digits));
      chk("dig_vld", 32'(dig_vld), 32'(m_dvld));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (!rst && ev_valid && ev_ready) begin
        r.idx = ev_idx; r.val = ev_val; r.err = ev_err; r.blank = ev_blank;
        log_q.push_back(r);
      end
    end
  end

  task automatic cyc(input logic [3:0] en, input logic [6:0] s, input logic rdy, input int n);
    dig_en = en; seg = s; ev_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input int k, input int idx, input int val, input int err, input int blank);
    if (k >= log_q.size()) begin
      checks++; errors++;
      $display("FAIL log_entry %0d: got none expected idx %0d val %0h", k, idx, val);
    end else begin
      chk("log_idx", 32'(log_q[k].idx), 32'(idx));
      chk("log_val", 32'(log_q[k].val), 32'(val));
      chk("log_err", 32'(log_q[k].err), 32'(err));
      chk("log_blank", 32'(log_q[k].blank), 32'(blank));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ev_valid), 0);
    chk({tag, "_idx"}, 32'(ev_idx), 0);
    chk({tag, "_val"}, 32'(ev_val), 0);
    chk({tag, "_err"}, 32'(ev_err), 0);
    chk({tag, "_blank"}, 32'(ev_blank), 0);
    chk({tag, "_digits"}, 32'(digits), 0);
    chk({tag, "_dig_vld"}, 32'(dig_vld), 0);
    chk({tag, "_ovf"}, 32'(ovf), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    chk_all_zero("reset");

    // Digit 0 shows "2": capture after the 4th edge, then drained
    cyc(4'b0001, 7'b1101101, 1'b0, 3);
    chk("t1_no_early_ev", 32'(ev_valid), 0);
    cyc(4'b0001, 7'b1101101, 1'b0, 1);
    chk("t1_ev_valid", 32'(ev_valid), 1);
    chk("t1_ev_idx", 32'(ev_idx), 0);
    chk("t1_ev_val", 32'(ev_val), 2);
    chk("t1_digit0", 32'(digits[3:0]), 2);
    chk("t1_dig_vld", 32'(dig_vld), 4'b0001);
    cyc(4'b0001, 7'b1101101, 1'b1, 1);
    chk("t1_drained", 32'(ev_valid), 0);

    // Pattern change before stable restarts the window
    log_q.delete();
    cyc(4'b0010, 7'b1101101, 1'b1, 3);
    chk("t2_short_window", 32'(ev_valid), 0);
    cyc(4'b0010, 7'b1111001, 1'b1, 3);
    chk("t2_restart", 32'(ev_valid), 0);
    cyc(4'b0010, 7'b1111001, 1'b1, 1);
    chk("t2_ev_valid", 32'(ev_valid), 1);
    chk("t2_ev_idx", 32'(ev_idx), 1);
    chk("t2_ev_val", 32'(ev_val), 3);
    cyc(4'b0010, 7'b1111001, 1'b1, 1);
    chk("t2_log_size", 32'(log_q.size()), 1);

    // Two scan rounds: first round reports, second is silent
    log_q.delete();
    for (int r = 0; r < 2; r++) begin
      cyc(4'b0001, 7'b1111110, 1'b1, 4);
      cyc(4'b0010, 7'b0110000, 1'b1, 4);
      cyc(4'b0100, 7'b1110111, 1'b1, 4);
      cyc(4'b1000, 7'b1000111, 1'b1, 4);
    end
    cyc(4'b0000, 7'b0, 1'b1, 2);
    chk("t3_log_size", 32'(log_q.size()), 4);
    chk_log(0, 0, 4'h0, 0, 0);
    chk_log(1, 1, 4'h1, 0, 0);
    chk_log(2, 2, 4'hA, 0, 0);
    chk_log(3, 3, 4'hF, 0, 0);
    chk("t3_digits", 32'(digits), 16'hFA10);
    chk("t3_dig_vld", 32'(dig_vld), 4'hF);
    chk("t3_model_digits", 32'(m_digits), 16'hFA10);

    // Illegal pattern then blank on digit 2
    log_q.delete();
    cyc(4'b0100, 7'b1010101, 1'b1, 4);
    chk("t4_err", 32'(ev_err), 1);
    chk("t4_err_val", 32'(ev_val), 0);
    chk("t4_err_idx", 32'(ev_idx), 2);
    chk("t4_digit2_kept", 32'(digits[11:8]), 4'hA);
    chk("t4_vld2_kept", 32'(dig_vld[2]), 1);
    cyc(4'b0100, 7'b1010101, 1'b1, 4);
    chk("t4_err_once", 32'(log_q.size()), 1);
    cyc(4'b0100, 7'b0000000, 1'b1, 4);
    chk("t4_blank", 32'(ev_blank), 1);
    chk("t4_blank_val", 32'(ev_val), 0);
    chk("t4_blank_vld", 32'(dig_vld), 4'b1011);
    cyc(4'b0000, 7'b0, 1'b1, 1);
    cyc(4'b0100, 7'b0000000, 1'b1, 4);
    chk("t4_blank_silent", 32'(ev_valid), 0);

    // Back-pressure: reload on transfer edge, then a dropped event
    cyc(4'b0001, 7'b1011011, 1'b0, 4);
    chk("t5_first_val", 32'(ev_val), 5);
    cyc(4'b0010, 7'b1011111, 1'b0, 3);
    chk("t5_held_idx", 32'(ev_idx), 0);
    chk("t5_held_val", 32'(ev_val), 5);
    cyc(4'b0010, 7'b1011111, 1'b1, 1);
    chk("t5_reload_valid", 32'(ev_valid), 1);
    chk("t5_reload_idx", 32'(ev_idx), 1);
    chk("t5_reload_val", 32'(ev_val), 6);
    chk("t5_no_ovf", 32'(ovf), 0);
    cyc(4'b0001, 7'b1110000, 1'b0, 4);
    chk("t5_ovf", 32'(ovf), 1);
    chk("t5_kept_idx", 32'(ev_idx), 1);
    chk("t5_kept_val", 32'(ev_val), 6);
    chk("t5_digit0", 32'(digits[3:0]), 7);

    // Non-one-hot enables never capture
    cyc(4'b0011, 7'b1111111, 1'b1, 10);
    chk("t6_no_event", 32'(ev_valid), 0);
    chk("t6_digits", 32'(digits), 16'hFA67);
    chk("t6_model_digits", 32'(m_digits), 16'hFA67);

    // Async reset with event pending and mid-count
    cyc(4'b0100, 7'b1111011, 1'b0, 4);
    chk("t6_pending", 32'(ev_valid), 1);
    cyc(4'b1000, 7'b0110011, 1'b0, 2);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full glyph sweep on digit 3
    log_q.delete();
    for (int v = 0; v < 16; v++) cyc(4'b1000, glyph[v], 1'b1, 4);
    cyc(4'b0000, 7'b0, 1'b1, 2);
    chk("sweep_log_size", 32'(log_q.size()), 16);
    for (int v = 0; v < 16; v++) chk_log(v, 3, v, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
